// File: rtl/uart_rx_if.sv
// Receive-side bus of the UART: serial line in, byte buffer handshake and sticky status out.
interface uart_rx_if;
  logic       RXD;
  logic       rx_ready;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  // master: the receiver, which owns the byte buffer and status flags
  modport master (
    input  RXD, rx_ready, err_clr,
    output rx_data, rx_valid, frame_err, overrun, busy
  );

  // slave: the pin driver plus the I/O-space consumer
  modport slave (
    output RXD, rx_ready, err_clr,
    input  rx_data, rx_valid, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-FF input synchroniser, one-entry valid/ready byte buffer and sticky error flags.
// rx_valid rises HALF_BIT + 9*CLKS_PER_BIT + 2 cycles after RXD is first sampled low; a full buffer drops bytes into overrun.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input logic      CLK,
  input logic      RESET,
  uart_rx_if.master bus
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state_q;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             busy_q;

  logic rxd_s;
  logic can_accept;

  assign rxd_s      = sync_q[1];
  assign can_accept = !rx_valid_q || bus.rx_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.RXD};

      // Clears and the consume come first so a same-cycle set or reload overrides them.
      if (bus.err_clr) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            if (!rxd_s) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            shreg_q   <= {rxd_s, shreg_q[7:1]};
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rxd_s) begin
              if (can_accept) begin
                rx_data_q  <= shreg_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BREAK: begin
          // Hold here while the line stays low so a break is not read as a stream of 0x00 bytes.
          if (rxd_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: a table of whole frames plus hand sequences for timing corners.
module tb_uart_rx;

  localparam int C = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   k;
  int   pulses;
  logic [7:0] got [2];

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic       exp_vld;
    logic [7:0] exp_dat;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.RXD = bits[i];
      repeat (C - 1) @(negedge clk);
    end
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{din: 8'hA5, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'hA5, exp_ferr: 1'b0};
    vecs[1] = '{din: 8'h3C, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'h3C, exp_ferr: 1'b0};
    vecs[2] = '{din: 8'h55, stop: 1'b0, exp_vld: 1'b0, exp_dat: 8'h3C, exp_ferr: 1'b1};
    vecs[3] = '{din: 8'h81, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'h81, exp_ferr: 1'b0};
    vecs[4] = '{din: 8'h00, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'h00, exp_ferr: 1'b0};
    vecs[5] = '{din: 8'hFF, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'hFF, exp_ferr: 1'b0};

    rst          = 1'b1;
    bus.RXD      = 1'b1;
    bus.rx_ready = 1'b0;
    bus.err_clr  = 1'b0;
    #1;
    chk("reset_data",  bus.rx_data,   8'h00);
    chk("reset_valid", bus.rx_valid,  1'b0);
    chk("reset_ferr",  bus.frame_err, 1'b0);
    chk("reset_ovr",   bus.overrun,   1'b0);
    chk("reset_busy",  bus.busy,      1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (C) @(negedge clk);

    // First-byte latency, counted in edges from E0.
    k = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(negedge clk);
        while (k < 400) begin
          @(posedge clk);
          k++;
          #1;
          if (k == 1) chk("busy_e0p1", bus.busy, 1'b0);
          if (k == 2) chk("busy_e0p2", bus.busy, 1'b1);
          if (bus.rx_valid) break;
        end
      end
    join
    chk("latency_edges", k, 154);
    repeat (C) @(negedge clk);
    chk("lat_data",  bus.rx_data,   8'hA5);
    chk("lat_ferr",  bus.frame_err, 1'b0);
    chk("lat_busy",  bus.busy,      1'b0);
    chk("lat_hold",  bus.rx_valid,  1'b1);
    pulse_ready();
    chk("lat_consumed", bus.rx_valid, 1'b0);

    // Back-to-back frames with the consumer always ready.
    @(negedge clk);
    bus.rx_ready = 1'b1;
    pulses = 0;
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        repeat (20 * C + 40) begin
          @(posedge clk);
          #1;
          if (bus.rx_valid) begin
            if (pulses < 2) got[pulses] = bus.rx_data;
            pulses++;
          end
        end
      end
    join
    chk("b2b_pulses", pulses, 2);
    chk("b2b_first",  got[0], 8'h00);
    chk("b2b_second", got[1], 8'hFF);
    chk("b2b_ovr",    bus.overrun, 1'b0);
    @(negedge clk);
    bus.rx_ready = 1'b0;

    // Short low glitch on the line.
    @(negedge clk);
    bus.RXD = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_busy_hi", bus.busy, 1'b1);
    @(negedge clk);
    bus.RXD = 1'b1;
    repeat (C) @(negedge clk);
    chk("glitch_busy_lo", bus.busy,      1'b0);
    chk("glitch_valid",   bus.rx_valid,  1'b0);
    chk("glitch_ferr",    bus.frame_err, 1'b0);
    chk("glitch_ovr",     bus.overrun,   1'b0);
    send_frame(8'h3C, 1'b1);
    repeat (C) @(negedge clk);
    chk("glitch_next_data",  bus.rx_data,  8'h3C);
    chk("glitch_next_valid", bus.rx_valid, 1'b1);
    pulse_ready();

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].din, vecs[i].stop);
      bus.RXD = 1'b1;
      repeat (C) @(negedge clk);
      chk($sformatf("vec%0d_valid", i), bus.rx_valid,  vecs[i].exp_vld);
      chk($sformatf("vec%0d_data",  i), bus.rx_data,   vecs[i].exp_dat);
      chk($sformatf("vec%0d_ferr",  i), bus.frame_err, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_busy",  i), bus.busy,      1'b0);
      pulse_ready();
      chk($sformatf("vec%0d_drained", i), bus.rx_valid, 1'b0);
      pulse_clr();
      chk($sformatf("vec%0d_ferr_clr", i), bus.frame_err, 1'b0);
    end

    // Framing error with the line held low as a break.
    send_frame(8'h55, 1'b0);
    repeat (3 * C) @(negedge clk);
    chk("brk_ferr",  bus.frame_err, 1'b1);
    chk("brk_valid", bus.rx_valid,  1'b0);
    chk("brk_busy",  bus.busy,      1'b1);
    bus.RXD = 1'b1;
    repeat (4) @(negedge clk);
    chk("brk_busy_lo", bus.busy,      1'b0);
    chk("brk_ferr_sticky", bus.frame_err, 1'b1);
    pulse_clr();
    chk("brk_ferr_clr", bus.frame_err, 1'b0);

    // Overrun: second byte arrives while the first is still held.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (C) @(negedge clk);
    chk("ovr_data",  bus.rx_data,  8'h11);
    chk("ovr_valid", bus.rx_valid, 1'b1);
    chk("ovr_flag",  bus.overrun,  1'b1);
    pulse_ready();
    chk("ovr_drained", bus.rx_valid, 1'b0);
    chk("ovr_sticky",  bus.overrun,  1'b1);

    // Reset in the middle of a frame's data bits.
    fork
      send_frame(8'h81, 1'b1);
      begin
        repeat (60) @(negedge clk);
        chk("mid_busy", bus.busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_data",  bus.rx_data,   8'h00);
        chk("mid_rst_valid", bus.rx_valid,  1'b0);
        chk("mid_rst_ovr",   bus.overrun,   1'b0);
        chk("mid_rst_ferr",  bus.frame_err, 1'b0);
        chk("mid_rst_busy",  bus.busy,      1'b0);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    send_frame(8'h81, 1'b1);
    repeat (C) @(negedge clk);
    chk("post_rst_data",  bus.rx_data,  8'h81);
    chk("post_rst_valid", bus.rx_valid, 1'b1);
    chk("post_rst_ferr",  bus.frame_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
